// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with
// one 32-bit word per line, sitting between the pipeline memory stage and a
// single-outstanding-request backing memory.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset
//   MEM        in   2   request: 00 none, 01 read, 10 write, 11 reserved (= none)
//   Addr       in  32   byte address (bits [1:0] ignored)
//   Wdata      in  32   store data
//   Rdata      out 32   load data (registered)
//   BUSY       out  1   pipeline stall request (combinational)
//   mem_req    out  1   backing-memory request (registered)
//   mem_we     out  1   backing-memory write enable (registered)
//   mem_addr   out 32   backing-memory word address (registered)
//   mem_wdata  out 32   backing-memory write data (registered)
//   mem_rdata  in  32   backing-memory read data, valid with mem_ack
//   mem_ack    in   1   backing-memory completion pulse
module data_cache #(
  parameter int LINES       = 16,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        BUSY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - IDX_W - 2;
  localparam int WAIT_W = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [31:0]        data_r [LINES];
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [LINES-1:0]   valid_r;
  logic [31:0]        rdata_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [31:0]        mem_addr_r;
  logic [31:0]        mem_wdata_r;
  logic [WAIT_W-1:0]  wait_cnt_r;

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic               is_rd_s;
  logic               is_wr_s;
  logic               busy_s;
  logic               load_hit_s;
  logic               issue_s;
  logic               fill_s;
  logic               wr_done_s;
  logic               addr_unused_s;

  assign idx_s         = Addr[IDX_W+1:2];
  assign tag_s         = Addr[31:IDX_W+2];
  assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign is_rd_s       = (MEM == 2'b01);
  assign is_wr_s       = (MEM == 2'b10);
  assign addr_unused_s = ^Addr[1:0];

  assign BUSY      = busy_s;
  assign Rdata     = rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, stall and datapath strobes. Inputs are only interpreted in
  // IDLE; the wait states rely on the pipeline holding them stable.
  always_comb begin
    state_nx_s = state_r;
    busy_s     = 1'b0;
    load_hit_s = 1'b0;
    issue_s    = 1'b0;
    fill_s     = 1'b0;
    wr_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_rd_s) begin
          if (hit_s) begin
            load_hit_s = 1'b1;
          end else begin
            busy_s     = 1'b1;
            issue_s    = 1'b1;
            state_nx_s = RD_MISS;
          end
        end else if (is_wr_s) begin
          busy_s     = 1'b1;
          issue_s    = 1'b1;
          state_nx_s = WR_THRU;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD_MISS: begin
        busy_s = 1'b1;
        if (mem_ack) begin
          fill_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RD_MISS;
        end
      end
      WR_THRU: begin
        busy_s = 1'b1;
        if (mem_ack) begin
          wr_done_s  = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = WR_THRU;
        end
      end
      // One non-stalling cycle lets the pipeline retire the request.
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Load data and backing-memory request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r     <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      if (load_hit_s) begin
        rdata_r <= data_r[idx_s];
      end else if (fill_s) begin
        rdata_r <= mem_rdata;
      end
      if (issue_s) begin
        mem_req_r  <= 1'b1;
        mem_we_r   <= is_wr_s;
        mem_addr_r <= {Addr[31:2], 2'b00};
        if (is_wr_s) begin
          mem_wdata_r <= Wdata;
        end
      end else if (fill_s || wr_done_s) begin
        mem_req_r <= 1'b0;
        mem_we_r  <= 1'b0;
      end
    end
  end

  // Valid bits: set on refill only, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Line data and tags are intentionally not reset; valid gates their use.
  // A write miss leaves the array untouched (no allocation).
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[idx_s] <= mem_rdata;
      tag_r[idx_s]  <= tag_s;
    end else if (wr_done_s && hit_s) begin
      data_r[idx_s] <= Wdata;
    end
  end

  // Saturating count of cycles spent waiting for mem_ack (debug observability).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= '0;
    end else if ((state_r == RD_MISS) || (state_r == WR_THRU)) begin
      if (wait_cnt_r != WAIT_W'(MEM_LAT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      wait_cnt_r <= '0;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: each access pushes its expected stall count,
// memory-request count and load data to a scoreboard queue; the entry is
// popped and compared when the access completes.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic [1:0]  MEM;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        BUSY;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          busy;
    int          req;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  data_cache #(.LINES(16), .MEM_LAT_MAX(255)) dut (
    .clk(clk), .rst(rst), .MEM(MEM), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata), .BUSY(BUSY), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Issue one request at a negedge, act as backing memory (ack on the lat-th
  // request cycle), and score the access once BUSY drops.
  task automatic access(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        input logic [31:0] mrdata, input int exp_busy,
                        input int exp_req, input logic [31:0] exp_rdata,
                        input string tag);
    exp_t e;
    exp_t got;
    int   busy_n;
    int   req_n;
    bit   done;
    e.busy  = exp_busy;
    e.req   = exp_req;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
    MEM    = op;
    Addr   = addr;
    Wdata  = wdata;
    busy_n = 0;
    req_n  = 0;
    done   = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!BUSY) done = 1'b1;
      else busy_n++;
      if (mem_req) begin
        req_n++;
        check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, (op == 2'b10)});
        if (op == 2'b10) check({tag, ".mem_wdata"}, mem_wdata, wdata);
        if (req_n == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mrdata;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (done) break;
    end
    mem_ack = 1'b0;
    if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check({tag, ".busy_cycles"}, busy_n, got.busy);
      check({tag, ".req_cycles"}, req_n, got.req);
      check({tag, ".rdata"}, Rdata, got.rdata);
      check({tag, ".req_idle"}, {31'd0, mem_req}, 32'd0);
    end
    MEM = 2'b00;
  endtask

  initial begin
    rst       = 1'b0;
    MEM       = 2'b00;
    Addr      = 32'h0000_0000;
    Wdata     = 32'h0000_0000;
    mem_rdata = 32'h0000_0000;
    mem_ack   = 1'b0;
    #1;
    check("rst.rdata", Rdata, 32'h0000_0000);
    check("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0000_0000);
    check("rst.mem_wdata", mem_wdata, 32'h0000_0000);
    check("rst.busy", {31'd0, BUSY}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, refill after 3 cycles; then a hit.
    access(2'b01, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 4, 3, 32'hDEAD_BEEF, "rd_miss_40");
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h0, 0, 0, 32'hDEAD_BEEF, "rd_hit_40");
    // Write hit goes through and updates the line; Rdata holds across the write.
    access(2'b10, 32'h0000_0040, 32'h1234_5678, 2, 32'h0, 3, 2, 32'hDEAD_BEEF, "wr_hit_40");
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h0, 0, 0, 32'h1234_5678, "rd_after_wr");
    // Write miss to the same index: no allocation, old line still hits.
    access(2'b10, 32'h0000_0080, 32'hCAFE_F00D, 1, 32'h0, 2, 1, 32'h1234_5678, "wr_miss_80");
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h0, 0, 0, 32'h1234_5678, "rd_40_noalloc");
    access(2'b01, 32'h0000_0080, 32'h0, 2, 32'hCAFE_F00D, 3, 2, 32'hCAFE_F00D, "rd_miss_80");
    // Alias on index 0 evicts; 0x40 must miss again.
    access(2'b01, 32'h0000_0400, 32'h0, 1, 32'h0BAD_CAFE, 2, 1, 32'h0BAD_CAFE, "rd_miss_400");
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 2, 1, 32'h1234_5678, "rd_remiss_40");
    access(2'b01, 32'h0000_0044, 32'h0, 1, 32'h1111_1111, 2, 1, 32'h1111_1111, "rd_miss_44");

    // Back-to-back hits, one per cycle with no stall.
    MEM  = 2'b01;
    Addr = 32'h0000_0040;
    #1;
    check("b2b.busy0", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    Addr = 32'h0000_0044;
    #1;
    check("b2b.rdata0", Rdata, 32'h1234_5678);
    check("b2b.busy1", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    MEM = 2'b00;
    #1;
    check("b2b.rdata1", Rdata, 32'h1111_1111);

    // Reserved encoding behaves as no request.
    MEM  = 2'b11;
    Addr = 32'h0000_0040;
    #1;
    check("rsvd.busy", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    #1;
    check("rsvd.rdata", Rdata, 32'h1111_1111);
    check("rsvd.mem_req", {31'd0, mem_req}, 32'd0);
    MEM = 2'b00;

    // Stray ack in IDLE is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray.mem_req", {31'd0, mem_req}, 32'd0);
    check("stray.rdata", Rdata, 32'h1111_1111);
    check("stray.busy", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h0, 0, 0, 32'h1234_5678, "rd_hit_after_stray");

    // Reset in the middle of a read miss, then a late ack.
    MEM  = 2'b01;
    Addr = 32'h0000_0048;
    @(negedge clk);
    #1;
    check("midrst.req_before", {31'd0, mem_req}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst.mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst.mem_addr", mem_addr, 32'h0000_0000);
    check("midrst.mem_wdata", mem_wdata, 32'h0000_0000);
    check("midrst.rdata", Rdata, 32'h0000_0000);
    MEM = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack.mem_req", {31'd0, mem_req}, 32'd0);
    check("late_ack.busy", {31'd0, BUSY}, 32'd0);
    check("late_ack.rdata", Rdata, 32'h0000_0000);
    @(negedge clk);
    access(2'b01, 32'h0000_0048, 32'h0, 1, 32'h7777_7777, 2, 1, 32'h7777_7777, "rd_48_after_rst");
    access(2'b01, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 2, 1, 32'h1234_5678, "rd_40_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
